// File: rtl/icache_axi_rd_bridge.sv
// AXI4 read master behind the ICache refill and uncached fetch ports.
// One transaction in flight: IDLE -> AR -> R -> DONE.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   line_rd_req/addr/rdy         line refill request and accept pulse
//   line_ret_valid/data          refilled line, word i at [32i+31:32i]
//   unc_rd_req/addr/rdy          uncached word request and accept pulse
//   unc_ret_valid/data           uncached word result
//   ret_err                      any accepted beat had rresp != OKAY
//   ar*, r*                      AXI4 AR and R channels
module icache_axi_rd_bridge #(
    parameter int         LINE_WORD_NUM = 4,
    parameter logic [3:0] LINE_ID       = 4'd0,
    parameter logic [3:0] UNC_ID        = 4'd1
) (
    input  logic                       clk,
    input  logic                       resetn,

    input  logic                       line_rd_req,
    input  logic [31:0]                line_rd_addr,
    output logic                       line_rd_rdy,
    output logic                       line_ret_valid,
    output logic [32*LINE_WORD_NUM-1:0] line_ret_data,

    input  logic                       unc_rd_req,
    input  logic [31:0]                unc_rd_addr,
    output logic                       unc_rd_rdy,
    output logic                       unc_ret_valid,
    output logic [31:0]                unc_ret_data,

    output logic                       ret_err,

    output logic [3:0]                 arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    input  logic                       arready,

    input  logic [3:0]                 rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready
);

    localparam int          CW       = $clog2(LINE_WORD_NUM);
    localparam logic [31:0] OFF_MASK = 32'(LINE_WORD_NUM * 4 - 1);
    localparam logic [CW-1:0] LAST_W = CW'(LINE_WORD_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DONE
    } state_t;

    state_t                       state;
    logic                         is_unc;
    logic [31:0]                  req_addr;
    logic [CW-1:0]                cnt;
    logic                         err;
    logic [32*LINE_WORD_NUM-1:0]  line_buf;
    logic [31:0]                  unc_buf;

    logic                         idle;
    logic                         in_ar;
    logic [3:0]                   cur_id;
    logic                         beat_ok;

    // rdy is combinational on req but suppressed while reset is held
    assign idle        = (state == IDLE) && resetn;
    assign unc_rd_rdy  = idle && unc_rd_req;
    assign line_rd_rdy = idle && line_rd_req && !unc_rd_req;

    assign in_ar   = (state == AR);
    assign cur_id  = is_unc ? UNC_ID : LINE_ID;
    assign beat_ok = (state == R) && rvalid && (rid == cur_id);

    // AR fields are zero outside AR so the bus is quiet when idle
    assign arvalid = in_ar;
    assign arid    = in_ar ? cur_id : 4'd0;
    assign araddr  = !in_ar ? 32'd0 :
                     is_unc ? req_addr : (req_addr & ~OFF_MASK);
    assign arlen   = (in_ar && !is_unc) ? 8'(LINE_WORD_NUM - 1) : 8'd0;
    assign arsize  = in_ar ? 3'b010 : 3'b000;
    assign arburst = in_ar ? 2'b01 : 2'b00;

    // Mismatched-ID beats are still drained, just not stored
    assign rready = (state == R);

    assign line_ret_valid = (state == DONE) && !is_unc;
    assign unc_ret_valid  = (state == DONE) && is_unc;
    assign ret_err        = (state == DONE) && err;
    assign line_ret_data  = line_buf;
    assign unc_ret_data   = unc_buf;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            is_unc   <= 1'b0;
            req_addr <= 32'd0;
            cnt      <= '0;
            err      <= 1'b0;
            line_buf <= '0;
            unc_buf  <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (unc_rd_req || line_rd_req) begin
                        is_unc   <= unc_rd_req;
                        req_addr <= unc_rd_req ? unc_rd_addr : line_rd_addr;
                        line_buf <= '0;
                        cnt      <= '0;
                        err      <= 1'b0;
                        state    <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        state <= R;
                    end
                end
                R: begin
                    if (beat_ok) begin
                        if (is_unc) begin
                            unc_buf <= rdata;
                        end else begin
                            line_buf[{cnt, 5'd0} +: 32] <= rdata;
                        end
                        cnt <= cnt + 1'b1;
                        if (rresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        // Stop at rlast or on the final word slot, so an
                        // overlong burst never wraps onto word 0
                        if (rlast || cnt == LAST_W) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Bench for icache_axi_rd_bridge: transaction model checked every cycle
// plus directed scenarios with literal expectations.
module tb_icache_axi_rd_bridge;

    localparam int N  = 4;
    localparam int LW = 32 * N;

    logic          clk = 1'b0;
    logic          resetn;
    logic          line_rd_req;
    logic [31:0]   line_rd_addr;
    logic          line_rd_rdy;
    logic          line_ret_valid;
    logic [LW-1:0] line_ret_data;
    logic          unc_rd_req;
    logic [31:0]   unc_rd_addr;
    logic          unc_rd_rdy;
    logic          unc_ret_valid;
    logic [31:0]   unc_ret_data;
    logic          ret_err;
    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [3:0]    rid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    icache_axi_rd_bridge #(
        .LINE_WORD_NUM(N),
        .LINE_ID(4'd0),
        .UNC_ID(4'd1)
    ) dut (
        .clk(clk), .resetn(resetn),
        .line_rd_req(line_rd_req), .line_rd_addr(line_rd_addr),
        .line_rd_rdy(line_rd_rdy), .line_ret_valid(line_ret_valid),
        .line_ret_data(line_ret_data),
        .unc_rd_req(unc_rd_req), .unc_rd_addr(unc_rd_addr),
        .unc_rd_rdy(unc_rd_rdy), .unc_ret_valid(unc_ret_valid),
        .unc_ret_data(unc_ret_data),
        .ret_err(ret_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- transaction model + per-cycle compare ----------
    initial begin : model
        int          ph;
        bit          ku;
        logic [3:0]  id;
        logic [31:0] aa;
        logic [7:0]  al;
        logic [31:0] w [N];
        int          cnt;
        bit          err;
        logic [31:0] u;
        bit          armed;
        bit          was_rst;
        bit          eu;
        bit          el;
        logic [LW-1:0] xl;
        ph = 0; ku = 0; id = 0; aa = 0; al = 0; cnt = 0; err = 0;
        u = 0; armed = 0; was_rst = 0;
        for (int i = 0; i < N; i++) w[i] = 0;
        forever begin
            @(negedge clk);
            eu = (ph == 0) && resetn && unc_rd_req;
            el = (ph == 0) && resetn && line_rd_req && !unc_rd_req;
            if (armed) begin
                chk("rdy", {line_rd_rdy, unc_rd_rdy}, {el, eu});
                chk("arvalid", arvalid, ph == 1);
                if (ph == 1)
                    chk("ar_fields", {arid, araddr, arlen, arsize, arburst},
                        {id, aa, al, 3'b010, 2'b01});
                chk("rready", rready, ph == 2);
                chk("ret_flags", {line_ret_valid, unc_ret_valid, ret_err},
                    {(ph == 3) && !ku, (ph == 3) && ku, (ph == 3) && err});
                if (ph == 3 && !ku) begin
                    for (int i = 0; i < N; i++) xl[32*i +: 32] = w[i];
                    chk("line_data", line_ret_data, xl);
                end
                if (ph == 3 && ku)
                    chk("unc_data", unc_ret_data, u);
                if (was_rst)
                    chk("rst_data", {line_ret_data, unc_ret_data}, 0);
            end
            if (!resetn) begin
                ph = 0; armed = 1; was_rst = 1; u = 0;
            end else begin
                was_rst = 0;
                case (ph)
                    0: if (eu || el) begin
                        ku  = eu;
                        id  = eu ? 4'd1 : 4'd0;
                        aa  = eu ? unc_rd_addr
                                 : (line_rd_addr & ~32'(N * 4 - 1));
                        al  = eu ? 8'd0 : 8'(N - 1);
                        cnt = 0; err = 0;
                        for (int i = 0; i < N; i++) w[i] = 0;
                        ph = 1;
                    end
                    1: if (arready) ph = 2;
                    2: if (rvalid && rid == id) begin
                        if (ku) u = rdata;
                        else w[cnt] = rdata;
                        cnt++;
                        if (rresp != 2'b00) err = 1;
                        if (rlast || cnt == N) ph = 3;
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------
    logic [3:0]  b_id   [16];
    logic [31:0] b_dat  [16];
    logic [1:0]  b_resp [16];
    logic        b_last [16];
    int          b_gap  [16];
    int          nb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [3:0] id,
                            input logic [31:0] d, input logic [1:0] rs,
                            input logic l, input int g);
        b_id[i] = id; b_dat[i] = d; b_resp[i] = rs;
        b_last[i] = l; b_gap[i] = g;
    endtask

    task automatic wait_rdy(input bit unc, output int c);
        bit got;
        got = 0;
        c = -1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (unc ? unc_rd_rdy : line_rd_rdy) begin
                got = 1;
                c = cyc;
            end
            tick();
        end
        if (!got) chk("rdy_timeout", 1, 0);
        if (unc) unc_rd_req = 0;
        else line_rd_req = 0;
    endtask

    task automatic send_beats();
        bit ok;
        for (int i = 0; i < nb; i++) begin
            rvalid = 0;
            for (int g = 0; g < b_gap[i]; g++) tick();
            rvalid = 1; rid = b_id[i]; rdata = b_dat[i];
            rresp = b_resp[i]; rlast = b_last[i];
            ok = 0;
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge clk);
                ok = rready;
                tick();
            end
            if (!ok) chk("beat_timeout", 1, 0);
        end
        rvalid = 0; rlast = 0; rresp = 0; rid = 0; rdata = 0;
    endtask

    task automatic wait_ret(output int c, output logic lv, output logic uv,
                            output logic e, output logic [LW-1:0] ld,
                            output logic [31:0] ud);
        bit got;
        got = 0;
        c = -1; lv = 0; uv = 0; e = 0; ld = 0; ud = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (line_ret_valid || unc_ret_valid) begin
                got = 1;
                c = cyc; lv = line_ret_valid; uv = unc_ret_valid;
                e = ret_err; ld = line_ret_data; ud = unc_ret_data;
            end
            tick();
        end
        if (!got) chk("ret_timeout", 1, 0);
    endtask

    // ---------------- directed scenarios ------------------------------
    initial begin : stim
        int            a, b, r, c0;
        logic          lv, uv, e;
        logic [LW-1:0] ld;
        logic [31:0]   ud;

        resetn = 0;
        line_rd_req = 0; line_rd_addr = 0;
        unc_rd_req = 0; unc_rd_addr = 0;
        arready = 1;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        repeat (3) tick();
        resetn = 1;
        @(negedge clk);
        chk("reset_outs",
            {arvalid, rready, line_rd_rdy, unc_rd_rdy, line_ret_valid,
             unc_ret_valid, ret_err, arid, araddr, arlen}, 0);
        chk("reset_data", {line_ret_data, unc_ret_data}, 0);
        tick();

        // line refill, zero wait states
        line_rd_addr = 32'h1FC0_0024; line_rd_req = 1;
        c0 = cyc;
        wait_rdy(0, a);
        chk("t1_rdy_cycle", a - c0, 0);
        @(negedge clk);
        chk("t1_ar", {arid, araddr, arlen}, {4'd0, 32'h1FC0_0020, 8'd3});
        tick();
        nb = 4;
        for (int i = 0; i < 4; i++)
            set_beat(i, 4'd0, 32'hA0 + 32'(i), 2'b00, i == 3, 0);
        send_beats();
        wait_ret(r, lv, uv, e, ld, ud);
        chk("t1_latency", r - a, 6);
        chk("t1_flags", {lv, uv, e}, 3'b100);
        chk("t1_line", ld, 128'h000000A3_000000A2_000000A1_000000A0);

        // uncached word
        unc_rd_addr = 32'hBFC0_0004; unc_rd_req = 1;
        wait_rdy(1, a);
        @(negedge clk);
        chk("t2_ar", {arid, araddr, arlen}, {4'd1, 32'hBFC0_0004, 8'd0});
        tick();
        nb = 1;
        set_beat(0, 4'd1, 32'hDEAD_BEEF, 2'b00, 1, 0);
        send_beats();
        wait_ret(r, lv, uv, e, ld, ud);
        chk("t2_latency", r - a, 3);
        chk("t2_flags", {lv, uv, e}, 3'b010);
        chk("t2_data", ud, 32'hDEAD_BEEF);

        // both requests together: uncached first, line next IDLE
        line_rd_addr = 32'h0000_2048; line_rd_req = 1;
        unc_rd_addr = 32'h1000_0008; unc_rd_req = 1;
        @(negedge clk);
        chk("t3_prio", {line_rd_rdy, unc_rd_rdy}, 2'b01);
        tick();
        unc_rd_req = 0;
        tick();
        nb = 1;
        set_beat(0, 4'd1, 32'h1234_5678, 2'b00, 1, 0);
        send_beats();
        wait_ret(r, lv, uv, e, ld, ud);
        chk("t3_unc", {lv, uv, e, ud}, {3'b010, 32'h1234_5678});
        wait_rdy(0, b);
        chk("t3_line_gap", b - r, 1);
        tick();
        nb = 4;
        for (int i = 0; i < 4; i++)
            set_beat(i, 4'd0, 32'h7700 + 32'(i), 2'b00, i == 3, 0);
        send_beats();
        wait_ret(r, lv, uv, e, ld, ud);
        chk("t3_line", {lv, uv, e, ld},
            {3'b100, 128'h00007703_00007702_00007701_00007700});

        // backpressure, gaps and a foreign-ID beat
        arready = 0;
        line_rd_addr = 32'h0000_1234; line_rd_req = 1;
        wait_rdy(0, a);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_ar_hold", {arvalid, arid, araddr, arlen},
                {1'b1, 4'd0, 32'h0000_1230, 8'd3});
            tick();
        end
        arready = 1;
        nb = 5;
        set_beat(0, 4'd0, 32'hB0, 2'b00, 0, 0);
        set_beat(1, 4'd2, 32'h55, 2'b00, 0, 1);
        set_beat(2, 4'd0, 32'hB1, 2'b00, 0, 2);
        set_beat(3, 4'd0, 32'hB2, 2'b00, 0, 0);
        set_beat(4, 4'd0, 32'hB3, 2'b00, 1, 1);
        send_beats();
        wait_ret(r, lv, uv, e, ld, ud);
        chk("t4_line", {lv, uv, e, ld},
            {3'b100, 128'h000000B3_000000B2_000000B1_000000B0});

        // error on first beat, rlast on second
        line_rd_addr = 32'h0000_0080; line_rd_req = 1;
        wait_rdy(0, a);
        tick();
        nb = 2;
        set_beat(0, 4'd0, 32'hC0, 2'b10, 0, 0);
        set_beat(1, 4'd0, 32'hC1, 2'b00, 1, 0);
        send_beats();
        wait_ret(r, lv, uv, e, ld, ud);
        chk("t5_latency", r - a, 4);
        chk("t5_line", {lv, uv, e, ld},
            {3'b101, 128'h00000000_00000000_000000C1_000000C0});

        // reset in the middle of a burst
        line_rd_addr = 32'h0000_0400; line_rd_req = 1;
        wait_rdy(0, a);
        tick();
        nb = 2;
        set_beat(0, 4'd0, 32'hD0, 2'b00, 0, 0);
        set_beat(1, 4'd0, 32'hD1, 2'b00, 0, 0);
        send_beats();
        resetn = 0;
        tick();
        resetn = 1;
        @(negedge clk);
        chk("t6_rst_outs",
            {arvalid, rready, line_rd_rdy, unc_rd_rdy, line_ret_valid,
             unc_ret_valid, ret_err, line_ret_data, unc_ret_data}, 0);
        tick();
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_ret", {line_ret_valid, unc_ret_valid}, 0);
            tick();
        end
        unc_rd_addr = 32'h0000_0010; unc_rd_req = 1;
        wait_rdy(1, a);
        tick();
        nb = 1;
        set_beat(0, 4'd1, 32'hCAFE_F00D, 2'b00, 1, 0);
        send_beats();
        wait_ret(r, lv, uv, e, ld, ud);
        chk("t6_after", {r - a, 29'd0, lv, uv, e, ud},
            {32'd3, 29'd0, 3'b010, 32'hCAFE_F00D});

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- AXI4 read-master bridge on the far side of the ICache miss and uncached ports.
- Accepts two request types from the cache's rd_req/rd_rdy/ret_valid interface:
  - Line refills: one full cache line.
  - Uncached fetches: one 32-bit word.
- Turns each accepted request into one AXI4 AR/R read transaction.
- For refills, assembles the returned beats into a LINE_WORD_NUM×32-bit line and hands it back with a one-cycle ret_valid pulse.

Parameters:
- LINE_WORD_NUM, 4, words per cache line = beats per refill burst (power of 2, 2..16).
- LINE_ID, 4'd0, AXI ID driven for line refills.
- UNC_ID, 4'd1, AXI ID driven for uncached reads.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- line_rd_req  in  1  line refill request; held high until accepted.
- line_rd_addr  in  32  refill address; offset bits are don't-care.
- line_rd_rdy  out  1  accept pulse for the line request.
- line_ret_valid  out  1  one-cycle pulse: line_ret_data valid.
- line_ret_data  out  32*LINE_WORD_NUM  refilled line; word i at bits [32i+31:32i].
- unc_rd_req  in  1  uncached read request; held high until accepted.
- unc_rd_addr  in  32  uncached word address.
- unc_rd_rdy  out  1  accept pulse for the uncached request.
- unc_ret_valid  out  1  one-cycle pulse: unc_ret_data valid.
- unc_ret_data  out  32  uncached read data.
- ret_err  out  1  pulses together with either ret_valid if any beat returned rresp != OKAY.
- arid  out  4  AR channel ID.
- araddr  out  32  AR channel address.
- arlen  out  8  AR channel burst length.
- arsize  out  3  AR channel beat size.
- arburst  out  2  AR channel burst type.
- arvalid  out  1  AR channel valid.
- arready  in  1  AR channel ready.
- rid  in  4  R channel ID.
- rdata  in  32  R channel data.
- rresp  in  2  R channel response.
- rlast  in  1  R channel last beat.
- rvalid  in  1  R channel valid.
- rready  out  1  R channel ready.

Behaviour:
- Reset: resetn is synchronous and active-low; clock is clk.
  - resetn low at a clk edge forces state IDLE, clears the beat counter, line buffer, error flag and unc_ret_data.
  - All outputs are 0 during and after reset until a request arrives (arvalid, rready, rdy, ret_valid, ret_err = 0).
- FSM states: IDLE, AR, R, DONE. Only one transaction is ever outstanding.
- IDLE:
  - If unc_rd_req: unc_rd_rdy=1 combinationally in the same cycle; latch type=UNC and the address; clear buffer, counter and error; go to AR.
  - Else if line_rd_req: line_rd_rdy=1, type=LINE, same latching; go to AR.
  - Fixed priority: uncached wins when both requests are high; the line request stays pending and is accepted in the next IDLE.
  - rdy is never high outside IDLE.
- AR:
  - arvalid=1; fields held stable until arready.
  - LINE: araddr = addr with low log2(LINE_WORD_NUM*4) bits cleared, arlen=LINE_WORD_NUM-1, arid=LINE_ID.
  - UNC: araddr = addr unchanged, arlen=0, arid=UNC_ID.
  - Both types: arsize=3'b010, arburst=2'b01 (INCR).
  - On arvalid&arready go to R. arvalid is 0 in all other states.
- R:
  - rready=1.
  - A beat is accepted when rvalid & rid == the driven arid.
  - Beats with a mismatched rid are consumed (rready stays 1) and their data dropped.
  - LINE: accepted beat k writes word[cnt], then cnt++.
  - UNC: the accepted beat writes unc_ret_data.
  - rresp != 2'b00 on any accepted beat sets the sticky err flag.
  - Go to DONE on an accepted beat with rlast=1, or when cnt reaches LINE_WORD_NUM-1 and accepts (whichever comes first).
- Short and long bursts:
  - Early rlast: words not yet written remain 0.
  - Beats after the counter saturates are not written (no wrap-around).
- DONE:
  - Pulse the type-matching ret_valid for exactly 1 cycle, with ret_err = err flag; go to IDLE.
  - line_ret_data and unc_ret_data hold their values until the next accepted request clears or overwrites them.
- Latency (arready=1, rvalid every cycle):
  - Request accepted at cycle 0 → arvalid at cycle 1.
  - First beat at cycle 2 at the earliest.
  - ret_valid one cycle after the last beat: LINE_WORD_NUM=4 gives cycle 6; UNC gives cycle 3.
- Reset mid-transaction: return to IDLE immediately. No ret_valid for the aborted request; the AXI side is reset alongside.
- A request deasserted before rdy is never issued (rdy is combinational on req).

Test Plan:
- Line refill, line_rd_req=1, addr=0x1FC0_0024, arready=1, 4 beats 0xA0..0xA3 with rlast on the 4th → line_rd_rdy at cycle 0; araddr=0x1FC0_0020, arlen=3, arid=0; line_ret_valid at cycle 6 with line_ret_data=0x000000A3_000000A2_000000A1_000000A0, ret_err=0.
- Uncached read, unc addr=0xBFC0_0004, rdata=0xDEADBEEF → arlen=0, arid=1, araddr=0xBFC0_0004; unc_ret_valid 1 cycle with 0xDEADBEEF; line_ret_valid stays 0.
- Simultaneous line_rd_req and unc_rd_req → unc_rd_rdy first, line_rd_rdy=0; after unc_ret_valid and one IDLE cycle, line_rd_rdy=1 and the line burst is issued.
- Backpressure: arready low 5 cycles, gaps in rvalid, one beat with rid=2 inserted → AR fields stable while waiting; the rid=2 beat is ignored; the line still assembles correctly; ret_valid only after rlast.
- Error and early-last: beat 1 rresp=2'b10, rlast on beat 2 → line_ret_valid with ret_err=1; words 2 and 3 = 0.
- Reset asserted during R after 2 beats → all outputs 0 next cycle, state IDLE, no ret_valid; the next request completes normally.
